// File: rtl/ufm_rom_shadow_loader_pkg.sv
// ---------------------------------------------------------------------------
// ufm_loader_pkg
// Shared definitions for the UFM -> program RAM boot loader: FSM state
// encoding, header field positions and default image parameters.
// ---------------------------------------------------------------------------
package ufm_loader_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_HDR_REQ,
      ST_HDR_WAIT,
      ST_CHECK,
      ST_DAT_REQ,
      ST_DAT_WAIT,
      ST_WRITE,
      ST_DONE,
      ST_ERROR
   } state_e;

   localparam logic [15:0] MAGIC_DEFAULT     = 16'hA5C3;
   localparam int unsigned ROM_DEPTH_DEFAULT = 512;

   // Header word layout: {MAGIC, LEN}
   localparam int unsigned HDR_MAGIC_MSB = 31;
   localparam int unsigned HDR_MAGIC_LSB = 16;
   localparam int unsigned HDR_LEN_MSB   = 15;
   localparam int unsigned HDR_LEN_LSB   = 0;

   function automatic logic [31:0] swap_halves(input logic [31:0] w);
      return {w[15:0], w[31:16]};
   endfunction

endpackage

// File: rtl/ufm_rom_shadow_loader_if.sv
// ---------------------------------------------------------------------------
// ufm_rom_shadow_loader_if
// Bus bundle for the boot loader: Avalon-MM read port toward the UFM and the
// 32-bit write port of the PIC program RAM. Signal names keep the loader's
// point of view (o_* driven by the loader, i_* driven by the UFM).
//   master : the loader
//   slave  : UFM / program RAM side
// ---------------------------------------------------------------------------
interface ufm_rom_shadow_loader_if;
   logic [15:0] o_ufm_addr;
   logic        o_ufm_read;
   logic [1:0]  o_ufm_burstcount;
   logic [31:0] i_ufm_readdata;
   logic        i_ufm_waitrequest;
   logic        i_ufm_readdatavalid;
   logic [8:0]  o_rom_wr_addr;
   logic [31:0] o_rom_wr_data;
   logic [3:0]  o_rom_wr_be;
   logic        o_rom_wr_we;

   modport master (
      output o_ufm_addr, o_ufm_read, o_ufm_burstcount,
      output o_rom_wr_addr, o_rom_wr_data, o_rom_wr_be, o_rom_wr_we,
      input  i_ufm_readdata, i_ufm_waitrequest, i_ufm_readdatavalid
   );

   modport slave (
      input  o_ufm_addr, o_ufm_read, o_ufm_burstcount,
      input  o_rom_wr_addr, o_rom_wr_data, o_rom_wr_be, o_rom_wr_we,
      output i_ufm_readdata, i_ufm_waitrequest, i_ufm_readdatavalid
   );
endinterface

// File: rtl/ufm_rom_shadow_loader_reader.sv
// ---------------------------------------------------------------------------
// avmm_single_reader
// Single-outstanding Avalon-MM read handshake with response timeout.
//   SYS_CLK, user_reset_button : clock, async active-high reset
//   req_i        : caller is in a request state (read held until accepted)
//   wait_i       : caller is waiting for the response
//   waitrequest_i, readdatavalid_i, readdata_i : Avalon slave signals
//   read_o       : Avalon read strobe
//   accept_o     : read accepted this cycle
//   data_valid_o : response arrives this cycle (data_o valid next cycle)
//   timeout_o    : no response within TIMEOUT cycles of acceptance
//   data_o       : last captured response word
// ---------------------------------------------------------------------------
module avmm_single_reader #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic        SYS_CLK,
   input  logic        user_reset_button,
   input  logic        req_i,
   input  logic        wait_i,
   input  logic        waitrequest_i,
   input  logic        readdatavalid_i,
   input  logic [31:0] readdata_i,
   output logic        read_o,
   output logic        accept_o,
   output logic        data_valid_o,
   output logic        timeout_o,
   output logic [31:0] data_o
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   data_q, data_d;

   always_comb begin
      read_o       = req_i;
      accept_o     = req_i & ~waitrequest_i;
      data_valid_o = wait_i & readdatavalid_i;
      // A response on the last allowed cycle still wins over the timeout.
      timeout_o    = wait_i & ~readdatavalid_i & (cnt_q == LAST);
      // Counter is held at zero outside WAIT, so it starts fresh per accept.
      cnt_d        = wait_i ? cnt_q + CW'(1) : '0;
      data_d       = data_valid_o ? readdata_i : data_q;
      data_o       = data_q;
   end

   always_ff @(posedge SYS_CLK or posedge user_reset_button) begin
      if (user_reset_button) begin
         cnt_q  <= '0;
         data_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/ufm_rom_shadow_loader.sv
// ---------------------------------------------------------------------------
// ufm_rom_shadow_loader
// Boot-time copy of the PIC16F84 program image from the MAX10 UFM into the
// M9K program RAM. The PIC is held in reset until the image header has been
// validated and every word written.
//   SYS_CLK, user_reset_button : 50 MHz clock, async active-high reset
//   i_start          : loading may begin (level, sampled in IDLE only)
//   bus              : UFM Avalon read port + program RAM write port
//   o_pic_reset_hold : high until a successful load
//   o_busy           : loader is active
//   o_done / o_error : terminal status, cleared only by reset
//   o_word_count     : words written so far
// ---------------------------------------------------------------------------
module ufm_rom_shadow_loader
   import ufm_loader_pkg::*;
#(
   parameter logic [15:0] UFM_BASE    = 16'h0000,
   parameter int unsigned ROM_DEPTH   = ROM_DEPTH_DEFAULT,
   parameter logic [15:0] MAGIC       = MAGIC_DEFAULT,
   parameter int unsigned TIMEOUT     = 1024,
   parameter bit          SWAP_HALVES = 1'b0
) (
   input  logic                    SYS_CLK,
   input  logic                    user_reset_button,
   input  logic                    i_start,
   ufm_rom_shadow_loader_if.master bus,
   output logic                    o_pic_reset_hold,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_error,
   output logic [9:0]              o_word_count
);

   state_e      state_q, state_d;
   logic [9:0]  idx_q, idx_d;
   logic [15:0] len_q, len_d;
   logic [9:0]  count_q, count_d;

   logic        rd_req, rd_wait, rd_read, rd_accept, rd_valid, rd_timeout;
   logic [31:0] rd_data;
   logic [15:0] hdr_magic, hdr_len;

   assign rd_req    = (state_q == ST_HDR_REQ)  || (state_q == ST_DAT_REQ);
   assign rd_wait   = (state_q == ST_HDR_WAIT) || (state_q == ST_DAT_WAIT);
   assign hdr_magic = rd_data[HDR_MAGIC_MSB:HDR_MAGIC_LSB];
   assign hdr_len   = rd_data[HDR_LEN_MSB:HDR_LEN_LSB];

   avmm_single_reader #(
      .TIMEOUT (TIMEOUT)
   ) u_reader (
      .SYS_CLK           (SYS_CLK),
      .user_reset_button (user_reset_button),
      .req_i             (rd_req),
      .wait_i            (rd_wait),
      .waitrequest_i     (bus.i_ufm_waitrequest),
      .readdatavalid_i   (bus.i_ufm_readdatavalid),
      .readdata_i        (bus.i_ufm_readdata),
      .read_o            (rd_read),
      .accept_o          (rd_accept),
      .data_valid_o      (rd_valid),
      .timeout_o         (rd_timeout),
      .data_o            (rd_data)
   );

   always_comb begin
      state_d              = state_q;
      idx_d                = idx_q;
      len_d                = len_q;
      count_d              = count_q;
      bus.o_ufm_addr       = '0;
      bus.o_ufm_read       = rd_read;
      bus.o_ufm_burstcount = 2'd1;
      bus.o_rom_wr_addr    = '0;
      bus.o_rom_wr_data    = '0;
      bus.o_rom_wr_be      = '0;
      bus.o_rom_wr_we      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_start) state_d = ST_HDR_REQ;
         end
         ST_HDR_REQ: begin
            bus.o_ufm_addr = UFM_BASE;
            if (rd_accept) state_d = ST_HDR_WAIT;
         end
         ST_HDR_WAIT: begin
            if (rd_valid)        state_d = ST_CHECK;
            else if (rd_timeout) state_d = ST_ERROR;
         end
         ST_CHECK: begin
            if (hdr_magic != MAGIC || 32'(hdr_len) > ROM_DEPTH) begin
               state_d = ST_ERROR;
            end else if (hdr_len == '0) begin
               state_d = ST_DONE;
            end else begin
               len_d   = hdr_len;
               idx_d   = '0;
               state_d = ST_DAT_REQ;
            end
         end
         ST_DAT_REQ: begin
            bus.o_ufm_addr = UFM_BASE + 16'd1 + {6'd0, idx_q};
            if (rd_accept) state_d = ST_DAT_WAIT;
         end
         ST_DAT_WAIT: begin
            if (rd_valid)        state_d = ST_WRITE;
            else if (rd_timeout) state_d = ST_ERROR;
         end
         ST_WRITE: begin
            bus.o_rom_wr_we   = 1'b1;
            bus.o_rom_wr_be   = 4'hF;
            bus.o_rom_wr_addr = idx_q[8:0];
            bus.o_rom_wr_data = SWAP_HALVES ? swap_halves(rd_data) : rd_data;
            count_d           = idx_q + 10'd1;
            if (({6'd0, idx_q} + 16'd1) == len_q) begin
               state_d = ST_DONE;
            end else begin
               idx_d   = idx_q + 10'd1;
               state_d = ST_DAT_REQ;
            end
         end
         ST_DONE:  state_d = ST_DONE;
         ST_ERROR: state_d = ST_ERROR;
         default:  state_d = ST_IDLE;
      endcase

      o_busy           = !(state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
      o_done           = (state_q == ST_DONE);
      o_error          = (state_q == ST_ERROR);
      o_pic_reset_hold = (state_q != ST_DONE);
      o_word_count     = count_q;
   end

   always_ff @(posedge SYS_CLK or posedge user_reset_button) begin
      if (user_reset_button) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         len_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         count_q <= count_d;
      end
   end

endmodule
